// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for a 5-stage RISC-V pipeline
//             (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards
//             and MEM-resolved control redirects (taken branch, jal, jalr).
//             It freezes the pipeline while data memory is busy, flags a
//             sticky error when memory never answers, and keeps saturating
//             stall and flush performance counters.
//  Ports    :
//    clk, rst_n            clock (rising edge), synchronous active-low reset
//    id_rs1/id_rs2         source registers of the ID instruction
//    id_uses_rs1/rs2       ID instruction actually reads rs1/rs2
//    ex_rd, ex_memtoreg,   EX destination, load flag, register-write flag
//    ex_regwrite
//    mem_branch/zero/      MEM-stage control bits that resolve redirects
//    jal/jalr
//    mem_req, dmem_ready   MEM data access request / memory completion
//    pc_en .. mem_wb_en    stage-register load enables
//    *_flush               load a bubble into the stage register
//    redirect              PC takes the branch/jump target
//    mem_timeout           sticky memory-timeout error flag
//    stall_cycles          saturating count of cycles with pc_en=0
//    flush_count           saturating count of redirects
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memtoreg,
    input  logic             ex_regwrite,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jal,
    input  logic             mem_jalr,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             redirect,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_cnt_nxt;
    logic           timeout_nxt;
    logic           pipe_go;   // memory is satisfied: apply br/lu/normal rules
    logic           br;
    logic           lu;

    assign br = (mem_branch & mem_zero) | mem_jal | mem_jalr;

    // Register x0 is never a real dependency, so a load to x0 never stalls.
    assign lu = ex_memtoreg & ex_regwrite & (ex_rd != 5'd0) &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                 (id_uses_rs2 & (id_rs2 == ex_rd)));

    // ------------------------------------------------------------------
    // Next-state and Mealy outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = mem_timeout;
        pipe_go      = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        redirect     = 1'b0;

        case (state)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    // Whole pipeline freezes; a pending redirect waits for
                    // the ready cycle so it is counted exactly once.
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WCW'(1);
                end else begin
                    pipe_go = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    pipe_go      = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = ERROR;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end
            end
            ERROR: begin
                // Frozen until reset.
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (pipe_go) begin
            if (br) begin
                // Redirect squashes the younger instructions, including the
                // one in ID, so a concurrent load-use hazard is moot.
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                redirect     = 1'b1;
            end else if (lu) begin
                // Hold IF and ID, insert one bubble into EX; the load moves on
                // so the hazard clears on the following cycle.
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            redirect     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, wait counter, error flag and performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
            if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redirect && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl. Single-cycle
//             decode cases come from a vector table; multi-cycle behaviour
//             (memory wait, timeout, counters, reset) uses short sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //  if_id_flush, id_ex_flush, ex_mem_flush, redirect}
    localparam logic [8:0] O_ALL = 9'b11111_000_0;
    localparam logic [8:0] O_BR  = 9'b11111_111_1;
    localparam logic [8:0] O_LU  = 9'b00111_010_0;
    localparam logic [8:0] O_FRZ = 9'b00000_000_0;
    localparam logic [8:0] O_RST = 9'b00000_111_0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_memtoreg, ex_regwrite;
    logic             mem_branch, mem_zero, mem_jal, mem_jalr, mem_req, dmem_ready;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, redirect, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [8:0]       outs;

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, redirect};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_jal(mem_jal), .mem_jalr(mem_jalr),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .redirect(redirect),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       m2r;
        logic       rw;
        logic       branch;
        logic       zero;
        logic       jal;
        logic       jalr;
        logic       req;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int pass_cnt = 0;
    int total    = 0;
    int exp_stall;
    int exp_flush;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic [4:0] rd, input logic m2r,
                                input logic rw, input logic branch,
                                input logic zero, input logic jal,
                                input logic jalr, input logic req,
                                input logic rdy, input logic [8:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.m2r = m2r; v.rw = rw; v.branch = branch; v.zero = zero;
        v.jal = jal; v.jalr = jalr; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_rd = v.rd; ex_memtoreg = v.m2r; ex_regwrite = v.rw;
        mem_branch = v.branch; mem_zero = v.zero; mem_jal = v.jal;
        mem_jalr = v.jalr; mem_req = v.req; dmem_ready = v.rdy;
    endtask

    task automatic idle();
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1, O_ALL));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // mid-cycle, well away from either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // inputs: rs1 rs2 u1 u2 rd m2r rw br zero jal jalr req rdy
        vecs[0]  = mk(5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 0, 0, 0, 0, 0, 1, O_LU);  // lu on rs1
        vecs[1]  = mk(5'd0, 5'd1, 1, 1, 5'd0, 1, 1, 0, 0, 0, 0, 0, 1, O_ALL); // rd = x0
        vecs[2]  = mk(5'd3, 5'd7, 1, 1, 5'd7, 1, 1, 0, 0, 0, 0, 0, 1, O_LU);  // lu on rs2
        vecs[3]  = mk(5'd3, 5'd7, 1, 0, 5'd7, 1, 1, 0, 0, 0, 0, 0, 1, O_ALL); // rs2 unused
        vecs[4]  = mk(5'd5, 5'd1, 1, 1, 5'd5, 0, 1, 0, 0, 0, 0, 0, 1, O_ALL); // not a load
        vecs[5]  = mk(5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 1, O_ALL); // no regwrite
        vecs[6]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 1, O_BR);  // beq taken
        vecs[7]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 0, 1, O_ALL); // not taken
        vecs[8]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 1, O_BR);  // jal
        vecs[9]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 1, O_BR);  // jalr
        vecs[10] = mk(5'd5, 5'd1, 1, 0, 5'd5, 1, 1, 1, 1, 0, 0, 0, 1, O_BR);  // br + lu
        vecs[11] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, O_ALL); // mem ready now
        vecs[12] = mk(5'd9, 5'd1, 1, 0, 5'd9, 1, 1, 0, 0, 0, 0, 1, 1, O_LU);  // mem ready + lu

        idle();
        rst_n = 1'b0;

        // ---------------- reset ----------------
        tick();
        settle();
        check("reset_outputs", 32'(outs), 32'(O_RST));
        tick();
        rst_n = 1'b1;
        settle();
        check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        check("reset_flush_cnt", 32'(flush_count), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        check("reset_release_outputs", 32'(outs), 32'(O_ALL));

        // ---------------- vector table ----------------
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            settle();
            check($sformatf("vec%0d_outputs", i), 32'(outs), 32'(vecs[i].exp));
            if (vecs[i].exp == O_LU) exp_stall++;
            if (vecs[i].exp == O_BR) exp_flush++;
            tick();
        end
        idle();
        settle();
        check("table_stall_cnt", 32'(stall_cycles), 32'(exp_stall));
        check("table_flush_cnt", 32'(flush_count), 32'(exp_flush));

        // ---------------- load-use: one bubble then resume ----------------
        do_reset();
        apply(vecs[0]);
        settle();
        check("lu_stall_cycle", 32'(outs), 32'(O_LU));
        tick();
        ex_memtoreg = 1'b0;   // EX now holds the bubble
        ex_regwrite = 1'b0;
        settle();
        check("lu_next_cycle", 32'(outs), 32'(O_ALL));
        check("lu_stall_cnt", 32'(stall_cycles), 32'd1);
        tick();
        idle();

        // ---------------- memory wait 3 cycles ----------------
        do_reset();
        mem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("memwait_freeze%0d", c), 32'(outs), 32'(O_FRZ));
            tick();
        end
        dmem_ready = 1'b1;
        settle();
        check("memwait_ready", 32'(outs), 32'(O_ALL));
        tick();
        idle();
        settle();
        check("memwait_back_run", 32'(outs), 32'(O_ALL));
        check("memwait_stall_cnt", 32'(stall_cycles), 32'd3);

        // ---------------- memory wait with pending branch ----------------
        do_reset();
        mem_req = 1'b1;
        dmem_ready = 1'b0;
        mem_branch = 1'b1;
        mem_zero = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            check($sformatf("membr_freeze%0d", c), 32'(outs), 32'(O_FRZ));
            tick();
        end
        check("membr_no_early_flush", 32'(flush_count), 32'd0);
        dmem_ready = 1'b1;
        settle();
        check("membr_redirect", 32'(outs), 32'(O_BR));
        tick();
        idle();
        settle();
        check("membr_flush_cnt", 32'(flush_count), 32'd1);
        check("membr_after", 32'(outs), 32'(O_ALL));
        tick();
        check("membr_flush_cnt_stable", 32'(flush_count), 32'd1);

        // ---------------- timeout (MAX_WAIT=4) and saturation ----------------
        do_reset();
        mem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < MAX_WAIT; c++) begin
            settle();
            check($sformatf("tmo_freeze%0d", c), 32'(outs), 32'(O_FRZ));
            check($sformatf("tmo_flag_low%0d", c), 32'(mem_timeout), 32'd0);
            tick();
        end
        settle();
        check("tmo_flag_set", 32'(mem_timeout), 32'd1);
        dmem_ready = 1'b1;
        settle();
        check("tmo_ready_ignored", 32'(outs), 32'(O_FRZ));
        tick();
        check("tmo_flag_sticky", 32'(mem_timeout), 32'd1);
        for (int c = 0; c < 20; c++) tick();
        check("tmo_stall_saturated", 32'(stall_cycles), 32'((1 << CNT_W) - 1));
        check("tmo_still_frozen", 32'(outs), 32'(O_FRZ));
        idle();
        do_reset();
        settle();
        check("tmo_reset_clears", 32'(mem_timeout), 32'd0);
        check("tmo_reset_stall_cnt", 32'(stall_cycles), 32'd0);
        check("tmo_reset_run", 32'(outs), 32'(O_ALL));

        // ---------------- reset in the middle of a memory wait ----------------
        mem_req = 1'b1;
        dmem_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        settle();
        check("midrst_outputs", 32'(outs), 32'(O_RST));
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        check("midrst_run", 32'(outs), 32'(O_ALL));
        check("midrst_stall_cnt", 32'(stall_cycles), 32'd0);
        check("midrst_flush_cnt", 32'(flush_count), 32'd0);
        mem_jal = 1'b1;
        settle();
        check("midrst_resume_jal", 32'(outs), 32'(O_BR));
        tick();
        idle();
        check("midrst_resume_flush_cnt", 32'(flush_count), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire
